// File: rtl/alu_8bit_if.sv
// Operand/result bundle for alu_8bit; the flags signal exists only when ALU_FLAGS_EN is defined.
// master drives operands and opcode, slave (the ALU) returns the registered result.
interface alu_8bit_if;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;
    localparam int unsigned SEL_W = 4;

    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             enable;
    logic [SEL_W-1:0] opcode;
    logic [RES_W-1:0] out;
    logic             out_valid;
`ifdef ALU_FLAGS_EN
    logic [2:0]       flags;

    modport master (output a, b, enable, opcode, input out, out_valid, flags);
    modport slave  (input a, b, enable, opcode, output out, out_valid, flags);
`else
    modport master (output a, b, enable, opcode, input out, out_valid);
    modport slave  (input a, b, enable, opcode, output out, out_valid);
`endif
endinterface

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU, 16 opcodes, 16-bit result, one cycle latency.
// Optional ALU_FLAGS_EN adds a registered {div_by_zero, carry, zero} flags output.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    alu_8bit_if.slave  bus
);
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_INC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_INV  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_XNOR = 4'd14;
    localparam logic [3:0] OP_BUF  = 4'd15;

    logic [RES_W-1:0] w_a16;
    logic [RES_W-1:0] w_b16;
    logic [RES_W-1:0] w_div;
    logic [RES_W-1:0] w_result;
    logic             w_b_zero;

    logic [RES_W-1:0] r_out;
    logic             r_valid;

    assign w_a16    = RES_W'(bus.a);
    assign w_b16    = RES_W'(bus.b);
    assign w_b_zero = (bus.b == '0);

    // Remainder in the high byte, quotient in the low byte; b==0 returns {a, FF}
    assign w_div = w_b_zero ? {bus.a, 8'hFF}
                            : {OP_W'(bus.a % bus.b), OP_W'(bus.a / bus.b)};

    always_comb begin
        w_result = '0;
        case (bus.opcode)
            OP_ADD:  w_result = w_a16 + w_b16;
            OP_INC:  w_result = w_a16 + RES_W'(1);
            OP_SUB:  w_result = w_a16 - w_b16;
            OP_DEC:  w_result = w_a16 - RES_W'(1);
            OP_MUL:  w_result = w_a16 * w_b16;
            OP_DIV:  w_result = w_div;
            OP_SHL:  w_result = w_a16 << 1;
            OP_SHR:  w_result = w_a16 >> 1;
            OP_AND:  w_result = {8'h00, bus.a & bus.b};
            OP_OR:   w_result = {8'h00, bus.a | bus.b};
            OP_INV:  w_result = {8'h00, ~bus.a};
            OP_NAND: w_result = {8'h00, ~(bus.a & bus.b)};
            OP_NOR:  w_result = {8'h00, ~(bus.a | bus.b)};
            OP_XOR:  w_result = {8'h00, bus.a ^ bus.b};
            OP_XNOR: w_result = {8'h00, ~(bus.a ^ bus.b)};
            OP_BUF:  w_result = w_a16;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.enable;
            if (bus.enable) begin
                r_out <= w_result;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;

`ifdef ALU_FLAGS_EN
    logic       w_carry;
    logic [2:0] w_flags;
    logic [2:0] r_flags;

    // Carry/borrow meaning depends on the opcode; non-arithmetic ops report 0
    always_comb begin
        w_carry = 1'b0;
        case (bus.opcode)
            OP_ADD:  w_carry = w_result[8];
            OP_SUB:  w_carry = (bus.a < bus.b);
            OP_INC:  w_carry = (bus.a == 8'hFF);
            OP_DEC:  w_carry = (bus.a == 8'h00);
            OP_SHL:  w_carry = bus.a[7];
            OP_SHR:  w_carry = bus.a[0];
            default: w_carry = 1'b0;
        endcase
    end

    assign w_flags = {(bus.opcode == OP_DIV) && w_b_zero, w_carry, (w_result == '0)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (bus.enable) begin
            r_flags <= w_flags;
        end
    end

    assign bus.flags = r_flags;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: stimulus pushes model results, a monitor pops on out_valid.
// Checks flags as well when ALU_FLAGS_EN is defined.
module tb_alu_8bit;
    typedef struct {
        logic [15:0] out;
        logic [2:0]  flags;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    exp_t exp_q[$];

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    endtask

    // Reference model: plain integer arithmetic, truncated to 16 bits at the end
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r;
        bit   c;
        bit   dz;
        r = 0; c = 0; dz = 0;
        case (op)
            0:  begin r = a + b; c = (a + b) > 255; end
            1:  begin r = a + 1; c = (a == 255); end
            2:  begin r = a - b; c = (a < b); end
            3:  begin r = a - 1; c = (a == 0); end
            4:  r = a * b;
            5:  if (b == 0) begin r = a * 256 + 255; dz = 1; end
                else r = (a % b) * 256 + a / b;
            6:  begin r = a * 2; c = (a >= 128); end
            7:  begin r = a / 2; c = (a % 2) == 1; end
            8:  r = a & b;
            9:  r = a | b;
            10: r = 255 - a;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = a ^ b;
            14: r = 255 - (a ^ b);
            default: r = a;
        endcase
        e.out   = 16'(r);
        e.flags = {dz, c, (e.out == 16'h0000)};
        return e;
    endfunction

    task automatic issue(input int op, input int a, input int b);
        @(negedge clk);
        bus.opcode = 4'(op);
        bus.a      = 8'(a);
        bus.b      = 8'(b);
        bus.enable = 1'b1;
        exp_q.push_back(model(op, a, b));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            bus.opcode = 4'($urandom_range(15));
            bus.a      = 8'($urandom);
            bus.b      = 8'($urandom);
        end
    endtask

    // Monitor: out_valid must match pending expectations; on valid, compare the popped result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("out_valid", 16'(bus.out_valid), 16'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (bus.out_valid) begin
                    check("out", bus.out, e.out);
`ifdef ALU_FLAGS_EN
                    check("flags", 16'(bus.flags), 16'(e.flags));
`endif
                end
            end
        end
    end

    initial begin
        int dir_op[];
        int dir_a[];
        int dir_b[];
        n_total = 0;
        n_pass  = 0;
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.opcode = 4'd0;
        bus.a      = 8'd0;
        bus.b      = 8'd0;
        #2;
        check("reset_out", bus.out, 16'h0000);
        check("reset_valid", 16'(bus.out_valid), 16'h0000);
`ifdef ALU_FLAGS_EN
        check("reset_flags", 16'(bus.flags), 16'h0000);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors from the arithmetic, mul/div, logic and shift cases
        dir_op = '{0, 1, 2, 3, 4, 5, 5, 8, 9, 10, 11, 12, 13, 14, 15, 6, 7, 0, 2, 5};
        dir_a  = '{200, 255, 5, 0, 255, 100, 'h37, 'hA5, 'hA5, 'hA5, 'hA5, 'hA5, 'hA5, 'hA5, 'hA5, 'h81, 'h81, 'hFF, 7, 0};
        dir_b  = '{100, 0, 10, 0, 255, 7, 0, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 0, 0, 1, 7, 0};
        foreach (dir_op[i]) begin
            issue(dir_op[i], dir_a[i], dir_b[i]);
            idle(1);
        end
        // Same vectors back-to-back: out_valid must stay high
        foreach (dir_op[i]) issue(dir_op[i], dir_a[i], dir_b[i]);
        idle(1);

        // Hold: result must persist while inputs change with enable low
        issue(0, 1, 2);
        idle(1);
        @(posedge clk); #1;
        check("hold_out0", bus.out, 16'h0003);
        idle(1);
        @(posedge clk); #1;
        check("hold_out1", bus.out, 16'h0003);

        // Reset mid-stream with an enabled capture pending: out clears immediately
        @(negedge clk);
        bus.opcode = 4'd4;
        bus.a      = 8'd9;
        bus.b      = 8'd9;
        bus.enable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", bus.out, 16'h0000);
        check("midrst_valid", 16'(bus.out_valid), 16'h0000);
        @(negedge clk);
        bus.enable = 1'b0;
        rst        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle(1);
            @(posedge clk); #1;
            check("post_rst_out", bus.out, 16'h0000);
        end

        // Randomized traffic with random gaps
        for (int i = 0; i < 400; i++) begin
            issue(int'($urandom_range(15)), int'($urandom_range(255)),
                  ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255)));
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);
        @(posedge clk); #2;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
